// File: rtl/camera_frame_reader.sv
// camera_frame_reader
// HCLK-side consumer of the camera frame buffer. Requests a frame from the
// capture block, reads the dual-port RAM one 32-bit word at a time, splits
// each word into two RGB565 pixels (low half first) and streams them out on a
// valid/ready interface with SOF/EOL/EOF markers, then releases the buffer.
// Build option: define CAMREAD_TESTPAT_EN to add a TESTPAT input; when set at
// START the RAM is left alone and the stream carries the pixel index instead.

module camera_frame_reader #(
  parameter int H_PIXELS = 320,
  parameter int V_LINES  = 240,
  parameter int ADDR_W   = 16
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              START,
`ifdef CAMREAD_TESTPAT_EN
  input  logic              TESTPAT,
`endif
  output logic              DATA_VALID,
  input  logic              DATA_READY,
  output logic [ADDR_W-1:0] DualRAM_RADDR,
  input  logic [31:0]       DualRAM_RDATA,
  output logic [15:0]       PIX_DATA,
  output logic              PIX_VALID,
  input  logic              PIX_READY,
  output logic              PIX_SOF,
  output logic              PIX_EOL,
  output logic              PIX_EOF,
  output logic              BUSY,
  output logic              DONE
);

  localparam int FRAME_WORDS = (H_PIXELS * V_LINES) / 2;
  localparam int XW = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
  localparam int YW = (V_LINES > 1) ? $clog2(V_LINES) : 1;

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(FRAME_WORDS - 1);
  localparam logic [XW-1:0]     LAST_X    = XW'(H_PIXELS - 1);
  localparam logic [YW-1:0]     LAST_Y    = YW'(V_LINES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_READ,
    ST_REL
  } state_t;

  // Control state and registered handshake outputs
  state_t state_q;
  logic   dv_q;
  logic   busy_q;
  logic   done_q;

  // Two-flop synchroniser for the PCLK-domain ready level
  logic rdy_meta_q;
  logic rdy_s_q;

  // Read-address side: next word to fetch, end-of-frame flag, word in flight
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic              issue_done_q, issue_done_d;
  logic              rd_pend_q;

  // Two-entry word skid buffer; buf0 is the head, half selects its pixel
  logic [31:0] buf0_q, buf0_d;
  logic [31:0] buf1_q, buf1_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        half_q, half_d;

  // Pixel position within the frame
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  // Shared decode
  logic        pix_valid;
  logic        handshake;
  logic        pop;
  logic        last_x;
  logic        last_y;
  logic        frame_last;
  logic        issue;
  logic [2:0]  occupancy;
  logic [31:0] word_in;

  assign pix_valid  = (cnt_q != 2'd0);
  assign handshake  = pix_valid & PIX_READY;
  assign pop        = handshake & half_q;
  assign last_x     = (x_q == LAST_X);
  assign last_y     = (y_q == LAST_Y);
  assign frame_last = last_x & last_y;

  // A word may only be requested when the buffer can absorb it even if the
  // sink stalls forever: stored words plus the one in flight must leave a slot.
  assign occupancy = 3'(cnt_q) + 3'(rd_pend_q);
  assign issue = (((state_q == ST_ARM) & rdy_s_q) | (state_q == ST_READ))
               & ~issue_done_q
               & (occupancy < 3'd2);

`ifdef CAMREAD_TESTPAT_EN
  logic              tp_q;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [15:0]       tp_lo;

  // In test-pattern mode the word that would have come back from the RAM is
  // synthesised from the address of the word in flight: pixels 2n and 2n+1.
  always_comb begin
    pend_addr_d = issue ? raddr_q : pend_addr_q;
    tp_lo       = 16'({pend_addr_q, 1'b0});
    word_in     = tp_q ? {tp_lo | 16'd1, tp_lo} : DualRAM_RDATA;
  end

  // Remember which word is in flight so the pattern can be rebuilt from it
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      pend_addr_q <= '0;
    end else begin
      pend_addr_q <= pend_addr_d;
    end
  end

  assign DualRAM_RADDR = tp_q ? '0 : raddr_q;
`else
  assign word_in       = DualRAM_RDATA;
  assign DualRAM_RADDR = raddr_q;
`endif

  assign DATA_VALID = dv_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign PIX_VALID  = pix_valid;
  assign PIX_DATA   = half_q ? buf0_q[31:16] : buf0_q[15:0];
  assign PIX_SOF    = pix_valid & (x_q == '0) & (y_q == '0);
  assign PIX_EOL    = pix_valid & last_x;
  assign PIX_EOF    = pix_valid & frame_last;

  // Bring DATA_READY into HCLK before any decision is made on it
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      rdy_meta_q <= 1'b0;
      rdy_s_q    <= 1'b0;
    end else begin
      rdy_meta_q <= DATA_READY;
      rdy_s_q    <= rdy_meta_q;
    end
  end

  // Frame lifecycle: request, stream, release, then report completion
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      dv_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef CAMREAD_TESTPAT_EN
      tp_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (START) begin
            state_q <= ST_ARM;
            dv_q    <= 1'b1;
            busy_q  <= 1'b1;
`ifdef CAMREAD_TESTPAT_EN
            tp_q    <= TESTPAT;
`endif
          end
        end
        ST_ARM: begin
          if (rdy_s_q) begin
            state_q <= ST_READ;
          end
        end
        ST_READ: begin
          if (handshake && frame_last) begin
            state_q <= ST_REL;
            dv_q    <= 1'b0;
          end
        end
        ST_REL: begin
          if (!rdy_s_q) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          dv_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Word address walks 0..FRAME_WORDS-1 once and parks on the last word until idle
  always_comb begin
    raddr_d      = raddr_q;
    issue_done_d = issue_done_q;
    if (state_q == ST_IDLE) begin
      raddr_d      = '0;
      issue_done_d = 1'b0;
    end else if (issue) begin
      if (raddr_q == LAST_WORD) begin
        issue_done_d = 1'b1;
      end else begin
        raddr_d = raddr_q + ADDR_W'(1);
      end
    end
  end

  // Read-side registers, including the one-cycle RAM latency marker
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      raddr_q      <= '0;
      issue_done_q <= 1'b0;
      rd_pend_q    <= 1'b0;
    end else begin
      raddr_q      <= raddr_d;
      issue_done_q <= issue_done_d;
      rd_pend_q    <= issue;
    end
  end

  // Skid buffer: returning RAM words are pushed, a word is popped once both halves are taken
  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    cnt_d  = cnt_q;
    half_d = half_q;
    if (handshake) begin
      half_d = ~half_q;
    end
    case ({rd_pend_q, pop})
      2'b10: begin
        if (cnt_q == 2'd0) begin
          buf0_d = word_in;
        end else begin
          buf1_d = word_in;
        end
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        buf0_d = buf1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd2) begin
          buf0_d = buf1_q;
          buf1_d = word_in;
        end else begin
          buf0_d = word_in;
        end
      end
      default: begin
      end
    endcase
  end

  // Skid buffer storage
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      buf0_q <= '0;
      buf1_q <= '0;
      cnt_q  <= 2'd0;
      half_q <= 1'b0;
    end else begin
      buf0_q <= buf0_d;
      buf1_q <= buf1_d;
      cnt_q  <= cnt_d;
      half_q <= half_d;
    end
  end

  // Pixel position only moves when the sink actually takes a pixel
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (handshake) begin
      if (last_x) begin
        x_d = '0;
        y_d = last_y ? '0 : (y_q + YW'(1));
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  // Pixel position registers
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

// File: tb/tb_camera_frame_reader.sv
// tb_camera_frame_reader
// Scoreboard bench for camera_frame_reader on a small 8x4 frame. Expected
// pixels and flags are queued when a frame is started and compared against
// the stream whenever PIX_VALID is high; a pixel leaves the queue on handshake.

module tb_camera_frame_reader;

   localparam int H      = 8;
   localparam int V      = 4;
   localparam int NPIX   = H * V;
   localparam int NWORDS = NPIX / 2;
   localparam int AW     = 16;

   logic          HCLK = 1'b0;
   logic          HRESETn = 1'b0;
   logic          START = 1'b0;
   logic          DATA_READY = 1'b0;
   logic          PIX_READY = 1'b0;
`ifdef CAMREAD_TESTPAT_EN
   logic          TESTPAT = 1'b0;
`endif
   logic          DATA_VALID;
   logic [AW-1:0] DualRAM_RADDR;
   logic [31:0]   DualRAM_RDATA = '0;
   logic [15:0]   PIX_DATA;
   logic          PIX_VALID;
   logic          PIX_SOF;
   logic          PIX_EOL;
   logic          PIX_EOF;
   logic          BUSY;
   logic          DONE;

   int            errors = 0;
   int            checks = 0;
   int            doneCnt = 0;
   bit            randomReady = 1'b0;
   logic [15:0]   ramBase = '0;
   logic [AW-1:0] maxRaddr = '0;
   bit            raddrNonZero = 1'b0;
   logic [18:0]   sbQ[$];

   camera_frame_reader #(
      .H_PIXELS(H),
      .V_LINES (V),
      .ADDR_W  (AW)
   ) dut (
      .HCLK         (HCLK),
      .HRESETn      (HRESETn),
      .START        (START),
`ifdef CAMREAD_TESTPAT_EN
      .TESTPAT      (TESTPAT),
`endif
      .DATA_VALID   (DATA_VALID),
      .DATA_READY   (DATA_READY),
      .DualRAM_RADDR(DualRAM_RADDR),
      .DualRAM_RDATA(DualRAM_RDATA),
      .PIX_DATA     (PIX_DATA),
      .PIX_VALID    (PIX_VALID),
      .PIX_READY    (PIX_READY),
      .PIX_SOF      (PIX_SOF),
      .PIX_EOL      (PIX_EOL),
      .PIX_EOF      (PIX_EOF),
      .BUSY         (BUSY),
      .DONE         (DONE)
   );

   // Free-running 100 MHz-style clock
   always #5 HCLK = ~HCLK;

   // Synchronous RAM model: word n holds pixels base+2n (low) and base+2n+1 (high)
   always @(posedge HCLK) begin
      DualRAM_RDATA <= {16'(32'(ramBase) + 2 * 32'(DualRAM_RADDR) + 1),
                        16'(32'(ramBase) + 2 * 32'(DualRAM_RADDR))};
   end

   // Sink: always ready, or stalling roughly 30% of cycles
   initial begin
      forever begin
         @(posedge HCLK);
         #1;
         PIX_READY = randomReady ? ($urandom_range(0, 99) >= 30) : 1'b1;
      end
   end

   // Hard stop in case the design locks up somewhere a bounded wait cannot see
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Counts one comparison and reports it when the observed value differs
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Stream monitor: every valid pixel must match the head of the scoreboard
   always @(negedge HCLK) begin
      if (HRESETn) begin
         if (DONE) doneCnt++;
         if (BUSY && (DualRAM_RADDR > maxRaddr)) maxRaddr = DualRAM_RADDR;
         if (DualRAM_RADDR != '0) raddrNonZero = 1'b1;
         if (PIX_VALID) begin
            if (sbQ.size() == 0) begin
               checkOutput("unexpectedPixel", 32'(PIX_DATA), 32'hFFFF_FFFF);
            end else begin
               checkOutput("pixel", 32'({PIX_SOF, PIX_EOL, PIX_EOF, PIX_DATA}), 32'(sbQ[0]));
               if (PIX_READY) void'(sbQ.pop_front());
            end
         end
      end
   end

   // Queues the expected frame and plays the capture side of the handshake
   task automatic applyStimulus(input logic [15:0] base, input bit tp, input bit pokeStart);
      int n;
      int doneBefore;
      logic [15:0] pixVal;
      ramBase = base;
      for (int p = 0; p < NPIX; p++) begin
         pixVal = tp ? 16'(p) : 16'(32'(base) + p);
         sbQ.push_back({(p == 0), ((p % H) == H - 1), (p == NPIX - 1), pixVal});
      end
      maxRaddr     = '0;
      raddrNonZero = 1'b0;
      doneBefore   = doneCnt;

      @(posedge HCLK); #1;
      START = 1'b1;
`ifdef CAMREAD_TESTPAT_EN
      TESTPAT = tp;
`endif
      @(posedge HCLK); #1;
      START = 1'b0;

      n = 0;
      while (!DATA_VALID && n < 50) begin
         @(posedge HCLK); #1;
         n++;
      end
      checkOutput("dataValidUp", 32'(DATA_VALID), 32'd1);
      checkOutput("busyUp", 32'(BUSY), 32'd1);

      if (pokeStart) begin
         START = 1'b1;
         @(posedge HCLK); #1;
         START = 1'b0;
      end

      repeat (3) @(posedge HCLK);
      #1;
      DATA_READY = 1'b1;
      n = 0;
      do begin
         @(negedge HCLK);
         n++;
      end while (!PIX_VALID && n < 20);
      checkOutput("firstPixLatency", 32'(n), 32'd5);

      if (pokeStart) begin
         @(posedge HCLK); #1;
         START = 1'b1;
         @(posedge HCLK); #1;
         START = 1'b0;
      end

      n = 0;
      while (DATA_VALID && n < 2000) begin
         @(posedge HCLK); #1;
         n++;
      end
      checkOutput("dataValidDrop", 32'(DATA_VALID), 32'd0);
      checkOutput("scoreboardEmpty", 32'(sbQ.size()), 32'd0);

      repeat (2) @(posedge HCLK);
      #1;
      checkOutput("busyInRelease", 32'(BUSY), 32'd1);
      checkOutput("noEarlyDone", 32'(doneCnt - doneBefore), 32'd0);

      DATA_READY = 1'b0;
      n = 0;
      while (BUSY && n < 20) begin
         @(posedge HCLK); #1;
         n++;
      end
      checkOutput("busyDrop", 32'(BUSY), 32'd0);

      repeat (10) @(posedge HCLK);
      #1;
      checkOutput("doneCount", 32'(doneCnt - doneBefore), 32'd1);
      checkOutput("idleNoRequest", 32'(DATA_VALID), 32'd0);
      checkOutput("idleRaddr", 32'(DualRAM_RADDR), 32'd0);
      if (tp) begin
         checkOutput("testpatRaddrConst", 32'(raddrNonZero), 32'd0);
      end else begin
         checkOutput("raddrLastWord", 32'(maxRaddr), 32'(NWORDS - 1));
      end
   endtask

   // Starts a frame and pulls reset while pixels are streaming
   task automatic applyMidFrameReset();
      int n;
      ramBase = 16'h0300;
      for (int p = 0; p < NPIX; p++) begin
         sbQ.push_back({(p == 0), ((p % H) == H - 1), (p == NPIX - 1), 16'(32'h0300 + p)});
      end
      @(posedge HCLK); #1;
      START = 1'b1;
      @(posedge HCLK); #1;
      START = 1'b0;
      n = 0;
      while (!DATA_VALID && n < 50) begin
         @(posedge HCLK); #1;
         n++;
      end
      DATA_READY = 1'b1;
      repeat (12) @(posedge HCLK);
      #1;
      checkOutput("midReadBusy", 32'(BUSY), 32'd1);
      checkOutput("midReadPixValid", 32'(PIX_VALID), 32'd1);

      HRESETn = 1'b0;
      @(posedge HCLK);
      @(negedge HCLK);
      checkOutput("rstDataValid", 32'(DATA_VALID), 32'd0);
      checkOutput("rstPixValid", 32'(PIX_VALID), 32'd0);
      checkOutput("rstBusy", 32'(BUSY), 32'd0);
      checkOutput("rstRaddr", 32'(DualRAM_RADDR), 32'd0);
      checkOutput("rstDone", 32'(DONE), 32'd0);
      sbQ.delete();
      DATA_READY = 1'b0;
      repeat (3) @(posedge HCLK);
      #1;
      HRESETn = 1'b1;
   endtask

   // Test sequence
   initial begin
      $display("[TB] camera_frame_reader bench, %0dx%0d frame", H, V);
      HRESETn = 1'b0;
      repeat (3) @(posedge HCLK);
      @(negedge HCLK);
      checkOutput("resetDataValid", 32'(DATA_VALID), 32'd0);
      checkOutput("resetPixValid", 32'(PIX_VALID), 32'd0);
      checkOutput("resetPixData", 32'(PIX_DATA), 32'd0);
      checkOutput("resetBusy", 32'(BUSY), 32'd0);
      checkOutput("resetDone", 32'(DONE), 32'd0);
      checkOutput("resetRaddr", 32'(DualRAM_RADDR), 32'd0);
      @(posedge HCLK); #1;
      HRESETn = 1'b1;

      $display("[TB] frame with sink always ready");
      randomReady = 1'b0;
      applyStimulus(16'h0000, 1'b0, 1'b0);

      $display("[TB] frame with random sink stalls and stray START pulses");
      randomReady = 1'b1;
      applyStimulus(16'h1000, 1'b0, 1'b1);

      $display("[TB] reset in the middle of a frame");
      randomReady = 1'b0;
      applyMidFrameReset();

      $display("[TB] frame after reset recovery");
      applyStimulus(16'h2000, 1'b0, 1'b0);

`ifdef CAMREAD_TESTPAT_EN
      $display("[TB] test-pattern frame with random sink stalls");
      randomReady = 1'b1;
      ramBase = 16'h5000;
      applyStimulus(16'h5000, 1'b1, 1'b0);
      TESTPAT = 1'b0;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
